// File: rtl/mpu_pkg.sv
// MPU shared types and load-path dimension widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mpu_pkg;

  // Default geometry of the matrix register file.
  localparam int LOAD_M          = 2;
  localparam int LOAD_N          = 2;
  localparam int MATRIX_REG_SIZE = 16;
  localparam int LOAD_FP         = 32;

  // Field widths used on the load path.
  localparam int LOAD_DEST_W = $clog2(MATRIX_REG_SIZE);
  localparam int LOAD_MDIM_W = $clog2(LOAD_M + 1);
  localparam int LOAD_NDIM_W = $clog2(LOAD_N + 1);
  localparam int LOAD_ROW_W  = (LOAD_M > 1) ? $clog2(LOAD_M) : 1;
  localparam int LOAD_COL_W  = (LOAD_N > 1) ? $clog2(LOAD_N) : 1;

  // LOAD front-end controller states.
  typedef enum logic [0:0] {
    LOAD_IDLE   = 1'b0,
    LOAD_MATRIX = 1'b1
  } load_state_t;

endpackage

// File: rtl/mpu_load_ctrl.sv
// LOAD front end: streams row-major FP elements into a matrix register, then commits dims.
// Latency: each accepted beat is written exactly 1 cycle later; commit/done ride with the last write.
// Backpressure: element_ready_out is high for the whole load and low when idle; no stalls mid-load.
module mpu_load_ctrl
  import mpu_pkg::*;
#(
  parameter int FP               = LOAD_FP,
  parameter int M                = LOAD_M,
  parameter int N                = LOAD_N,
  parameter int MATRIX_REGISTERS = MATRIX_REG_SIZE,
  localparam int DEST_W = $clog2(MATRIX_REGISTERS),
  localparam int MDIM_W = $clog2(M + 1),
  localparam int NDIM_W = $clog2(N + 1),
  localparam int ROW_W  = (M > 1) ? $clog2(M) : 1,
  localparam int COL_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [MDIM_W-1:0] m_in,
  input  logic [NDIM_W-1:0] n_in,
  input  logic [FP-1:0]     element_in,
  input  logic              element_valid_in,
  output logic              element_ready_out,
  output logic              reg_wr_en_out,
  output logic [DEST_W-1:0] reg_wr_addr_out,
  output logic [ROW_W-1:0]  reg_row_out,
  output logic [COL_W-1:0]  reg_col_out,
  output logic [FP-1:0]     reg_data_out,
  output logic              reg_commit_out,
  output logic [MDIM_W-1:0] reg_m_out,
  output logic [NDIM_W-1:0] reg_n_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              error_out
);

  load_state_t       state, state_nxt;
  logic [DEST_W-1:0] dest_lat;
  logic [MDIM_W-1:0] m_lat;
  logic [NDIM_W-1:0] n_lat;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;

  logic idle;
  logic dims_ok;
  logic cmd_ok;
  logic cmd_bad;
  logic accept;
  logic col_last;
  logic row_last;
  logic last_beat;

  assign idle    = (state == LOAD_IDLE);
  assign dims_ok = (m_in != '0) && (int'(m_in) <= M) &&
                   (n_in != '0) && (int'(n_in) <= N);
  // Commands only count while idle; a start during a load is dropped silently.
  assign cmd_ok  = idle && start_in && dims_ok;
  assign cmd_bad = idle && start_in && !dims_ok;

  assign element_ready_out = (state == LOAD_MATRIX);
  assign busy_out          = (state == LOAD_MATRIX);
  assign accept            = element_valid_in && element_ready_out;

  assign col_last  = (NDIM_W'(col) == n_lat - NDIM_W'(1));
  assign row_last  = (MDIM_W'(row) == m_lat - MDIM_W'(1));
  assign last_beat = row_last && col_last;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD_IDLE;
    else      state <= state_nxt;
  end

  // Next state: enter on a legal command, leave as the final beat is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_IDLE:   if (cmd_ok)             state_nxt = LOAD_MATRIX;
      LOAD_MATRIX: if (accept && last_beat) state_nxt = LOAD_IDLE;
      default:                             state_nxt = LOAD_IDLE;
    endcase
  end

  // Command latch, row-major counters and the registered write/commit stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_lat        <= '0;
      m_lat           <= '0;
      n_lat           <= '0;
      row             <= '0;
      col             <= '0;
      reg_wr_en_out   <= 1'b0;
      reg_wr_addr_out <= '0;
      reg_row_out     <= '0;
      reg_col_out     <= '0;
      reg_data_out    <= '0;
      reg_commit_out  <= 1'b0;
      reg_m_out       <= '0;
      reg_n_out       <= '0;
      done_out        <= 1'b0;
      error_out       <= 1'b0;
    end else begin
      reg_wr_en_out  <= accept;
      reg_commit_out <= accept && last_beat;
      done_out       <= accept && last_beat;
      error_out      <= cmd_bad;

      if (cmd_ok) begin
        dest_lat <= dest_in;
        m_lat    <= m_in;
        n_lat    <= n_in;
        row      <= '0;
        col      <= '0;
      end

      if (accept) begin
        reg_wr_addr_out <= dest_lat;
        reg_row_out     <= row;
        reg_col_out     <= col;
        reg_data_out    <= element_in;
        if (col_last) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        // Dimensions only change on a completed load; they hold afterwards.
        if (last_beat) begin
          reg_m_out <= m_lat;
          reg_n_out <= n_lat;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpu_load_ctrl.sv
// Directed self-checking bench for mpu_load_ctrl.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: element_valid_in is driven with gaps to exercise idle beats.
module tb_mpu_load_ctrl;
  import mpu_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start_in;
  logic [LOAD_DEST_W-1:0] dest_in;
  logic [LOAD_MDIM_W-1:0] m_in;
  logic [LOAD_NDIM_W-1:0] n_in;
  logic [LOAD_FP-1:0]     element_in;
  logic                   element_valid_in;
  logic                   element_ready_out;
  logic                   reg_wr_en_out;
  logic [LOAD_DEST_W-1:0] reg_wr_addr_out;
  logic [LOAD_ROW_W-1:0]  reg_row_out;
  logic [LOAD_COL_W-1:0]  reg_col_out;
  logic [LOAD_FP-1:0]     reg_data_out;
  logic                   reg_commit_out;
  logic [LOAD_MDIM_W-1:0] reg_m_out;
  logic [LOAD_NDIM_W-1:0] reg_n_out;
  logic                   busy_out;
  logic                   done_out;
  logic                   error_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpu_load_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .start_in          (start_in),
    .dest_in           (dest_in),
    .m_in              (m_in),
    .n_in              (n_in),
    .element_in        (element_in),
    .element_valid_in  (element_valid_in),
    .element_ready_out (element_ready_out),
    .reg_wr_en_out     (reg_wr_en_out),
    .reg_wr_addr_out   (reg_wr_addr_out),
    .reg_row_out       (reg_row_out),
    .reg_col_out       (reg_col_out),
    .reg_data_out      (reg_data_out),
    .reg_commit_out    (reg_commit_out),
    .reg_m_out         (reg_m_out),
    .reg_n_out         (reg_n_out),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .error_out         (error_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every output packed into one vector, used for the all-zero reset checks.
  function automatic logic [63:0] all_outs();
    return 64'({element_ready_out, reg_wr_en_out, reg_wr_addr_out, reg_row_out, reg_col_out,
                reg_data_out, reg_commit_out, reg_m_out, reg_n_out, busy_out, done_out,
                error_out});
  endfunction

  // Expected per-cycle picture; write fields are compared only when a write is expected.
  task automatic cyc(input string tag, input logic busy, input logic wr, input logic commit,
                     input logic done, input logic err, input logic [LOAD_DEST_W-1:0] addr,
                     input logic [LOAD_ROW_W-1:0] row, input logic [LOAD_COL_W-1:0] col,
                     input logic [LOAD_FP-1:0] data, input logic [LOAD_MDIM_W-1:0] m,
                     input logic [LOAD_NDIM_W-1:0] n);
    chk({tag, " ctl"},
        64'({element_ready_out, busy_out, reg_wr_en_out, reg_commit_out, done_out, error_out}),
        64'({busy, busy, wr, commit, done, err}));
    if (wr)
      chk({tag, " wr"}, 64'({reg_wr_addr_out, reg_row_out, reg_col_out, reg_data_out}),
          64'({addr, row, col, data}));
    chk({tag, " dims"}, 64'({reg_m_out, reg_n_out}), 64'({m, n}));
  endtask

  task automatic issue(input logic [LOAD_DEST_W-1:0] d, input logic [LOAD_MDIM_W-1:0] m,
                       input logic [LOAD_NDIM_W-1:0] n);
    start_in = 1'b1;
    dest_in  = d;
    m_in     = m;
    n_in     = n;
    tick();
    start_in = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start_in = 1'b0; dest_in = '0; m_in = '0; n_in = '0;
    element_in = '0; element_valid_in = 1'b0;
    #2;
    chk("reset outputs", all_outs(), 64'd0);
    #10 rst = 1'b1;

    // 1: 2x2 into reg 5, valid held high.
    issue(4'd5, 2'd2, 2'd2);
    cyc("t1 start", 1, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0, 2'd0, 2'd0);
    element_valid_in = 1'b1;
    element_in = 32'h3F800000; tick();
    cyc("t1 w00", 1, 1, 0, 0, 0, 4'd5, 1'b0, 1'b0, 32'h3F800000, 2'd0, 2'd0);
    element_in = 32'h40000000; tick();
    cyc("t1 w01", 1, 1, 0, 0, 0, 4'd5, 1'b0, 1'b1, 32'h40000000, 2'd0, 2'd0);
    element_in = 32'h40400000; tick();
    cyc("t1 w10", 1, 1, 0, 0, 0, 4'd5, 1'b1, 1'b0, 32'h40400000, 2'd0, 2'd0);
    element_in = 32'h40800000; tick();
    cyc("t1 w11", 0, 1, 1, 1, 0, 4'd5, 1'b1, 1'b1, 32'h40800000, 2'd2, 2'd2);
    element_valid_in = 1'b0; tick();
    cyc("t1 after", 0, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0, 2'd2, 2'd2);

    // 2: illegal dimensions, with valid high while idle.
    element_valid_in = 1'b1;
    issue(4'd6, 2'd0, 2'd2);
    cyc("t2 m0", 0, 0, 0, 0, 1, 4'd0, 1'b0, 1'b0, 32'h0, 2'd2, 2'd2);
    issue(4'd6, 2'd3, 2'd1);
    cyc("t2 m3", 0, 0, 0, 0, 1, 4'd0, 1'b0, 1'b0, 32'h0, 2'd2, 2'd2);
    issue(4'd6, 2'd1, 2'd3);
    cyc("t2 n3", 0, 0, 0, 0, 1, 4'd0, 1'b0, 1'b0, 32'h0, 2'd2, 2'd2);
    tick();
    cyc("t2 quiet", 0, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0, 2'd2, 2'd2);
    element_valid_in = 1'b0;

    // 3: 1x2 into reg 15, valid pattern 1,0,0,1.
    issue(4'd15, 2'd1, 2'd2);
    cyc("t3 start", 1, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0, 2'd2, 2'd2);
    element_valid_in = 1'b1; element_in = 32'h11111111; tick();
    cyc("t3 w00", 1, 1, 0, 0, 0, 4'd15, 1'b0, 1'b0, 32'h11111111, 2'd2, 2'd2);
    element_valid_in = 1'b0; element_in = 32'hDEADBEEF; tick();
    cyc("t3 gap1", 1, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0, 2'd2, 2'd2);
    tick();
    cyc("t3 gap2", 1, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0, 2'd2, 2'd2);
    element_valid_in = 1'b1; element_in = 32'h22222222; tick();
    cyc("t3 w01", 0, 1, 1, 1, 0, 4'd15, 1'b0, 1'b1, 32'h22222222, 2'd1, 2'd2);
    element_valid_in = 1'b0; tick();
    cyc("t3 after", 0, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0, 2'd1, 2'd2);

    // 4: reset after 2 of 4 beats, then a fresh 2x2 load.
    issue(4'd3, 2'd2, 2'd2);
    element_valid_in = 1'b1; element_in = 32'hAAAA0001; tick();
    cyc("t4 w00", 1, 1, 0, 0, 0, 4'd3, 1'b0, 1'b0, 32'hAAAA0001, 2'd1, 2'd2);
    element_in = 32'hAAAA0002; tick();
    cyc("t4 w01", 1, 1, 0, 0, 0, 4'd3, 1'b0, 1'b1, 32'hAAAA0002, 2'd1, 2'd2);
    #2 rst = 1'b0;
    #1 chk("t4 reset outputs", all_outs(), 64'd0);
    element_valid_in = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    cyc("t4 post", 0, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0, 2'd0, 2'd0);
    issue(4'd7, 2'd2, 2'd2);
    element_valid_in = 1'b1;
    element_in = 32'h00000001; tick();
    cyc("t4 r00", 1, 1, 0, 0, 0, 4'd7, 1'b0, 1'b0, 32'h00000001, 2'd0, 2'd0);
    element_in = 32'h00000002; tick();
    cyc("t4 r01", 1, 1, 0, 0, 0, 4'd7, 1'b0, 1'b1, 32'h00000002, 2'd0, 2'd0);
    element_in = 32'h00000003; tick();
    cyc("t4 r10", 1, 1, 0, 0, 0, 4'd7, 1'b1, 1'b0, 32'h00000003, 2'd0, 2'd0);
    element_in = 32'h00000004; tick();
    cyc("t4 r11", 0, 1, 1, 1, 0, 4'd7, 1'b1, 1'b1, 32'h00000004, 2'd2, 2'd2);
    element_valid_in = 1'b0;

    // 5: 2x1 into reg 9, with a competing start mid-load.
    issue(4'd9, 2'd2, 2'd1);
    cyc("t5 start", 1, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0, 2'd2, 2'd2);
    start_in = 1'b1; dest_in = 4'd4; m_in = 2'd1; n_in = 2'd1;
    element_valid_in = 1'b1; element_in = 32'h55555555; tick();
    start_in = 1'b0;
    cyc("t5 w00", 1, 1, 0, 0, 0, 4'd9, 1'b0, 1'b0, 32'h55555555, 2'd2, 2'd2);
    element_in = 32'h66666666; tick();
    cyc("t5 w10", 0, 1, 1, 1, 0, 4'd9, 1'b1, 1'b0, 32'h66666666, 2'd2, 2'd1);

    // 6: new command issued in the done cycle.
    element_valid_in = 1'b0;
    issue(4'd2, 2'd1, 2'd1);
    cyc("t6 restart", 1, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0, 2'd2, 2'd1);
    element_valid_in = 1'b1; element_in = 32'h77777777; tick();
    cyc("t6 w00", 0, 1, 1, 1, 0, 4'd2, 1'b0, 1'b0, 32'h77777777, 2'd1, 2'd1);
    element_valid_in = 1'b0; tick();
    cyc("t6 after", 0, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0, 2'd1, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
